// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : ID-stage sequencer for an RV32I pipeline. Scoreboards in-flight
//            register writes, stalls IF and IF/ID on RAW hazards with a bubble
//            into ID/EX, and runs a flush sequence after an EX redirect.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            id_*_i              - decoder view of the instruction in IF/ID
//            ex_redirect_i       - one-cycle taken jump/branch pulse from EX
//            stall_if_o/stall_id_o/bubble_ex_o/flush_if_id_o/id_issue_o
//                                - pipeline register controls
//            fwd_sel1_o/fwd_sel2_o - bypass selects (0 = register file)
//            stall_cnt_o         - count of stall_id cycles, wraps at 2^32
// Config   : HAZARD_FORWARD_EN - enables bypassing; only load-use stalls
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int WB_LAT       = 3,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid_i,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic        id_rs1_used_i,
   input  logic        id_rs2_used_i,
   input  logic [4:0]  id_rd_i,
   input  logic        id_reg_wen_i,
   input  logic        id_is_load_i,
   input  logic        ex_redirect_i,
   output logic        stall_if_o,
   output logic        stall_id_o,
   output logic        bubble_ex_o,
   output logic        flush_if_id_o,
   output logic        id_issue_o,
   output logic [1:0]  fwd_sel1_o,
   output logic [1:0]  fwd_sel2_o,
   output logic [31:0] stall_cnt_o
);

   localparam int C_CNT_W = $clog2(WB_LAT + 1);
   localparam int C_FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(WB_LAT);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
   localparam logic [C_FL_W-1:0]  C_FL_LOAD  = C_FL_W'(FLUSH_CYCLES - 1);
   localparam logic [C_FL_W-1:0]  C_FL_ONE   = C_FL_W'(1);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t              state_q;
   logic [C_FL_W-1:0]   flush_cnt_q;
   logic [C_CNT_W-1:0]  cnt_q [32];
   logic [31:0]         stall_cnt_q;
   logic [31:0]         stall_cnt_d;

   logic       w_pend1, w_pend2;
   logic       w_busy1, w_busy2, w_hazard;
   logic [1:0] w_fwd1, w_fwd2;
   logic       w_stall, w_bubble, w_flush, w_issue;
   logic       w_sb_write;

   // A source is pending when it is read, is not x0, and a write is in flight.
   assign w_pend1 = id_rs1_used_i && (id_rs1_i != 5'd0) && (cnt_q[id_rs1_i] != '0);
   assign w_pend2 = id_rs2_used_i && (id_rs2_i != 5'd0) && (cnt_q[id_rs2_i] != '0);

`ifdef HAZARD_FORWARD_EN
   logic [31:0] load_q;

   // Only a load issued last cycle cannot be bypassed yet (load-use bubble).
   assign w_busy1 = w_pend1 && load_q[id_rs1_i] && (cnt_q[id_rs1_i] == C_CNT_LOAD);
   assign w_busy2 = w_pend2 && load_q[id_rs2_i] && (cnt_q[id_rs2_i] == C_CNT_LOAD);
   // Counter value maps onto how many stages ahead the producer sits.
   assign w_fwd1  = w_pend1 ? 2'(WB_LAT + 1 - int'(cnt_q[id_rs1_i])) : 2'd0;
   assign w_fwd2  = w_pend2 ? 2'(WB_LAT + 1 - int'(cnt_q[id_rs2_i])) : 2'd0;
`else
   logic w_unused_load;

   assign w_busy1       = w_pend1;
   assign w_busy2       = w_pend2;
   assign w_fwd1        = 2'd0;
   assign w_fwd2        = 2'd0;
   assign w_unused_load = id_is_load_i;
`endif

   assign w_hazard = w_busy1 || w_busy2;

   // Zero-latency control outputs; a redirect overrides any hazard stall.
   always_comb begin
      w_stall  = 1'b0;
      w_bubble = 1'b0;
      w_flush  = 1'b0;
      w_issue  = 1'b0;
      if (rst) begin
         w_stall = 1'b0;
      end else if ((state_q == ST_FLUSH) || ex_redirect_i) begin
         w_flush  = 1'b1;
         w_bubble = 1'b1;
      end else if (!id_valid_i) begin
         w_bubble = 1'b1;
      end else if (w_hazard) begin
         w_stall  = 1'b1;
         w_bubble = 1'b1;
      end else begin
         w_issue = 1'b1;
      end
   end

   assign w_sb_write  = w_issue && id_reg_wen_i && (id_rd_i != 5'd0);
   assign stall_cnt_d = stall_cnt_q + {31'd0, w_stall};

   assign stall_if_o    = w_stall;
   assign stall_id_o    = w_stall;
   assign bubble_ex_o   = w_bubble;
   assign flush_if_id_o = w_flush;
   assign id_issue_o    = w_issue;
   assign fwd_sel1_o    = rst ? 2'd0 : w_fwd1;
   assign fwd_sel2_o    = rst ? 2'd0 : w_fwd2;
   assign stall_cnt_o   = rst ? 32'd0 : stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
         for (int r = 0; r < 32; r++) begin
            cnt_q[r] <= '0;
         end
`ifdef HAZARD_FORWARD_EN
         load_q <= '0;
`endif
      end else begin
         stall_cnt_q <= stall_cnt_d;

         // Counters age every cycle regardless of stalls; x0 is never written.
         for (int r = 1; r < 32; r++) begin
            if (cnt_q[r] != '0) begin
               cnt_q[r] <= cnt_q[r] - C_CNT_ONE;
            end
         end
         // Later assignment wins over the decrement above.
         if (w_sb_write) begin
            cnt_q[id_rd_i] <= C_CNT_LOAD;
`ifdef HAZARD_FORWARD_EN
            load_q[id_rd_i] <= id_is_load_i;
`endif
         end

         // The redirect cycle itself is the first flush cycle, so the FLUSH
         // state covers the remaining FLUSH_CYCLES-1 cycles and is left when
         // the counter runs out.
         case (state_q)
            ST_RUN: begin
               if (ex_redirect_i) begin
                  flush_cnt_q <= C_FL_LOAD;
                  state_q     <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
               end
            end
            ST_FLUSH: begin
               if (ex_redirect_i) begin
                  flush_cnt_q <= C_FL_LOAD;
                  state_q     <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
               end else begin
                  flush_cnt_q <= flush_cnt_q - C_FL_ONE;
                  if (flush_cnt_q <= C_FL_ONE) begin
                     state_q <= ST_RUN;
                  end
               end
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl. A timestamp-based
//            reference model (issue cycle per register, flush end cycle)
//            predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   localparam int WB_LAT       = 3;
   localparam int FLUSH_CYCLES = 2;

`ifdef HAZARD_FORWARD_EN
   localparam int T1_STALLS = 0;
   localparam int T1_FWD    = 1;
   localparam int T2_STALLS = 0;
   localparam int T2_FWD    = 2;
   localparam int T3_STALLS = 1;
   localparam int T3_FWD    = 2;
`else
   localparam int T1_STALLS = 3;
   localparam int T1_FWD    = 0;
   localparam int T2_STALLS = 2;
   localparam int T2_FWD    = 0;
   localparam int T3_STALLS = 3;
   localparam int T3_FWD    = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_rs1_used;
   logic        id_rs2_used;
   logic [4:0]  id_rd;
   logic        id_reg_wen;
   logic        id_is_load;
   logic        ex_redirect;
   logic        stall_if;
   logic        stall_id;
   logic        bubble_ex;
   logic        flush_if_id;
   logic        id_issue;
   logic [1:0]  fwd_sel1;
   logic [1:0]  fwd_sel2;
   logic [31:0] stall_cnt;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .WB_LAT       (WB_LAT),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid_i    (id_valid),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_rs1_used_i (id_rs1_used),
      .id_rs2_used_i (id_rs2_used),
      .id_rd_i       (id_rd),
      .id_reg_wen_i  (id_reg_wen),
      .id_is_load_i  (id_is_load),
      .ex_redirect_i (ex_redirect),
      .stall_if_o    (stall_if),
      .stall_id_o    (stall_id),
      .bubble_ex_o   (bubble_ex),
      .flush_if_id_o (flush_if_id),
      .id_issue_o    (id_issue),
      .fwd_sel1_o    (fwd_sel1),
      .fwd_sel2_o    (fwd_sel2),
      .stall_cnt_o   (stall_cnt)
   );

   // ---------------------------------------------------------------------
   // Reference model: a register is in flight for WB_LAT cycles after the
   // cycle it was issued in; its age is the bypass distance.
   // ---------------------------------------------------------------------
   int  cyc;
   int  iss_cyc [32];
   bit  iss_ld  [32];
   int  flush_end;
   int  stcnt;

   // {stall_if, stall_id, bubble_ex, flush_if_id, id_issue, fwd1, fwd2, stall_cnt}
   logic [40:0] e_vec;
   logic [40:0] act;

   int n_cmp;
   int n_fail;

   function automatic void model_clear();
      for (int r = 0; r < 32; r++) begin
         iss_cyc[r] = -100;
         iss_ld[r]  = 1'b0;
      end
      flush_end = -100;
      stcnt     = 0;
   endfunction

   function automatic void model_eval();
      int         a1, a2;
      bit         p1, p2, h1, h2, fl;
      logic [1:0] f1, f2;
      bit         sid, bub, fls, iss;
      a1 = cyc - iss_cyc[id_rs1];
      a2 = cyc - iss_cyc[id_rs2];
      p1 = id_rs1_used && (id_rs1 != 5'd0) && (a1 >= 1) && (a1 <= WB_LAT);
      p2 = id_rs2_used && (id_rs2 != 5'd0) && (a2 >= 1) && (a2 <= WB_LAT);
`ifdef HAZARD_FORWARD_EN
      h1 = p1 && iss_ld[id_rs1] && (a1 == 1);
      h2 = p2 && iss_ld[id_rs2] && (a2 == 1);
      f1 = p1 ? a1[1:0] : 2'd0;
      f2 = p2 ? a2[1:0] : 2'd0;
`else
      h1 = p1;
      h2 = p2;
      f1 = 2'd0;
      f2 = 2'd0;
`endif
      fl  = ex_redirect || (cyc <= flush_end);
      sid = 1'b0;
      bub = 1'b0;
      fls = 1'b0;
      iss = 1'b0;
      if (rst) begin
         f1 = 2'd0;
         f2 = 2'd0;
      end else if (fl) begin
         fls = 1'b1;
         bub = 1'b1;
      end else if (!id_valid) begin
         bub = 1'b1;
      end else if (h1 || h2) begin
         sid = 1'b1;
         bub = 1'b1;
      end else begin
         iss = 1'b1;
      end
      e_vec = {sid, sid, bub, fls, iss, f1, f2, rst ? 32'd0 : 32'(stcnt)};
   endfunction

   function automatic void model_commit();
      if (rst) begin
         model_clear();
      end else begin
         if (e_vec[36] && id_reg_wen && (id_rd != 5'd0)) begin
            iss_cyc[id_rd] = cyc;
            iss_ld[id_rd]  = id_is_load;
         end
         if (ex_redirect) flush_end = cyc + FLUSH_CYCLES - 1;
         if (e_vec[39]) stcnt++;
      end
      cyc++;
   endfunction

   // Apply inputs for one cycle, then sample outputs at the falling edge.
   task automatic drive(input bit v, input logic [4:0] r1, input bit u1,
                        input logic [4:0] r2, input bit u2, input logic [4:0] rd,
                        input bit wen, input bit ld, input bit rdr, input bit rs);
      id_valid    = v;
      id_rs1      = r1;
      id_rs1_used = u1;
      id_rs2      = r2;
      id_rs2_used = u2;
      id_rd       = rd;
      id_reg_wen  = wen;
      id_is_load  = ld;
      ex_redirect = rdr;
      rst         = rs;
      @(negedge clk);
      model_eval();
      act = {stall_if, stall_id, bubble_ex, flush_if_id, id_issue, fwd_sel1, fwd_sel2, stall_cnt};
   endtask

   task automatic tick();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (act !== 41'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want %h", act, 41'd0);
      end
      tick();
      drive(1, 5'd3, 1, 5'd4, 1, 5'd3, 1, 0, 1, 1);
      n_cmp++;
      if (act !== e_vec) begin
         n_fail++;
         $display("FAIL reset_hold: got %h want %h", act, e_vec);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (act !== {5'b00100, 4'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL reset_idle: got %h want %h", act, {5'b00100, 4'd0, 32'd0});
      end
      tick();
   endtask

   task automatic test_raw_stall();
      int stalls = 0;
      idle(4);
      drive(1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0);
      n_cmp++;
      if (act !== e_vec || act[36] !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_producer_issue: got %h want %h", act, e_vec);
      end
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1, 5'd5, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0);
         n_cmp++;
         if (act !== e_vec) begin
            n_fail++;
            $display("FAIL raw_reader cycle %0d: got %h want %h", i, act, e_vec);
         end
         if (i == 0) begin
            n_cmp++;
            if (act[35:34] !== 2'(T1_FWD)) begin
               n_fail++;
               $display("FAIL raw_fwd_sel1: got %0d want %0d", act[35:34], T1_FWD);
            end
         end
         tick();
         if (act[36] === 1'b1) break;
         stalls++;
      end
      n_cmp++;
      if (stalls != T1_STALLS) begin
         n_fail++;
         $display("FAIL raw_stall_cycles: got %0d want %0d", stalls, T1_STALLS);
      end
   endtask

   task automatic test_raw_gap();
      int stalls = 0;
      idle(4);
      drive(1, 0, 0, 0, 0, 5'd6, 1, 0, 0, 0);
      tick();
      drive(1, 5'd1, 0, 5'd2, 0, 5'd0, 0, 0, 0, 0);
      n_cmp++;
      if (act !== e_vec) begin
         n_fail++;
         $display("FAIL gap_independent: got %h want %h", act, e_vec);
      end
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1, 5'd0, 0, 5'd6, 1, 5'd0, 0, 0, 0, 0);
         n_cmp++;
         if (act !== e_vec) begin
            n_fail++;
            $display("FAIL gap_reader cycle %0d: got %h want %h", i, act, e_vec);
         end
         if (i == 0) begin
            n_cmp++;
            if (act[33:32] !== 2'(T2_FWD)) begin
               n_fail++;
               $display("FAIL gap_fwd_sel2: got %0d want %0d", act[33:32], T2_FWD);
            end
         end
         tick();
         if (act[36] === 1'b1) break;
         stalls++;
      end
      n_cmp++;
      if (stalls != T2_STALLS) begin
         n_fail++;
         $display("FAIL gap_stall_cycles: got %0d want %0d", stalls, T2_STALLS);
      end
   endtask

   task automatic test_load_use();
      int         stalls = 0;
      logic [1:0] fwd_at_issue = 2'b11;
      idle(4);
      drive(1, 0, 0, 0, 0, 5'd7, 1, 1, 0, 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1, 5'd7, 1, 5'd7, 0, 5'd9, 1, 0, 0, 0);
         n_cmp++;
         if (act !== e_vec) begin
            n_fail++;
            $display("FAIL load_use cycle %0d: got %h want %h", i, act, e_vec);
         end
         tick();
         if (act[36] === 1'b1) begin
            fwd_at_issue = act[35:34];
            break;
         end
         stalls++;
      end
      n_cmp++;
      if (stalls != T3_STALLS) begin
         n_fail++;
         $display("FAIL load_use_stalls: got %0d want %0d", stalls, T3_STALLS);
      end
      n_cmp++;
      if (fwd_at_issue !== 2'(T3_FWD)) begin
         n_fail++;
         $display("FAIL load_use_fwd: got %0d want %0d", fwd_at_issue, T3_FWD);
      end
   endtask

   task automatic test_redirect_in_stall();
      int fl_cycles = 1;
      bit resumed   = 1'b0;
      idle(4);
      drive(1, 0, 0, 0, 0, 5'd9, 1, 1, 0, 0);
      tick();
      drive(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      n_cmp++;
      if (act !== e_vec || act[39] !== 1'b1) begin
         n_fail++;
         $display("FAIL redir_pre_stall: got %h want %h", act, e_vec);
      end
      tick();
      drive(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 1, 0);
      n_cmp++;
      if (act[40:36] !== 5'b00110) begin
         n_fail++;
         $display("FAIL redir_drop_stall: got %b want %b", act[40:36], 5'b00110);
      end
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
         n_cmp++;
         if (act !== e_vec) begin
            n_fail++;
            $display("FAIL redir_seq cycle %0d: got %h want %h", i, act, e_vec);
         end
         tick();
         if (act[37] !== 1'b1) begin
            resumed = act[36];
            break;
         end
         fl_cycles++;
      end
      n_cmp++;
      if (fl_cycles != FLUSH_CYCLES) begin
         n_fail++;
         $display("FAIL redir_flush_len: got %0d want %0d", fl_cycles, FLUSH_CYCLES);
      end
      n_cmp++;
      if (resumed !== 1'b1) begin
         n_fail++;
         $display("FAIL redir_resume_issue: got %b want 1", resumed);
      end
   endtask

   task automatic test_x0_and_double_redirect();
      int fl_cycles = 1;
      idle(4);
      drive(1, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0);
      tick();
      drive(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0);
      n_cmp++;
      if (act[40:32] !== 9'b00001_0000) begin
         n_fail++;
         $display("FAIL x0_no_stall: got %b want %b", act[40:32], 9'b00001_0000);
      end
      tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      n_cmp++;
      if (act !== e_vec || act[37] !== 1'b1) begin
         n_fail++;
         $display("FAIL redir_in_flush: got %h want %h", act, e_vec);
      end
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         n_cmp++;
         if (act !== e_vec) begin
            n_fail++;
            $display("FAIL reflush_seq cycle %0d: got %h want %h", i, act, e_vec);
         end
         tick();
         if (act[37] !== 1'b1) break;
         fl_cycles++;
      end
      n_cmp++;
      if (fl_cycles != FLUSH_CYCLES) begin
         n_fail++;
         $display("FAIL reflush_len: got %0d want %0d", fl_cycles, FLUSH_CYCLES);
      end
   endtask

   task automatic test_reset_mid_stall();
      idle(4);
      drive(1, 0, 0, 0, 0, 5'd3, 1, 1, 0, 0);
      tick();
      drive(1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      n_cmp++;
      if (act !== e_vec || act[39] !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_stall: got %h want %h", act, e_vec);
      end
      tick();
      drive(1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1);
      n_cmp++;
      if (act !== 41'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got %h want %h", act, 41'd0);
      end
      tick();
      drive(1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      n_cmp++;
      if (act !== {5'b00001, 4'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL rstmid_cleared: got %h want %h", act, {5'b00001, 4'd0, 32'd0});
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 9) != 0),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 99) == 0));
         n_cmp++;
         if (act !== e_vec) begin
            n_fail++;
            $display("FAIL random step %0d: got %h want %h", i, act, e_vec);
         end
         tick();
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      cyc    = 0;
      model_clear();
      test_reset();
      test_raw_stall();
      test_raw_gap();
      test_load_use();
      test_redirect_in_stall();
      test_x0_and_double_redirect();
      test_reset_mid_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
